// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle between decode/instruction memory and pc_fetch_unit.
//   master : fetch-unit side (drives Read_Address and the IF/ID register outputs)
//   slave  : environment side (decode control, instruction memory read data)
// Signals:
//   Stall, Branch_Taken, Branch_Offset, Jump, Jump_Target : control from decode
//   Instruction                                           : memory read data
//   Read_Address                                          : PC to memory
//   IF_ID_Instruction, IF_ID_PC_Plus1, IF_ID_Valid        : IF/ID register
//   Halted                                                : sticky halt flag
interface pc_fetch_unit_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              Stall;
   logic              Branch_Taken;
   logic [ADDR_W-1:0] Branch_Offset;
   logic              Jump;
   logic [ADDR_W-1:0] Jump_Target;
   logic [31:0]       Instruction;
   logic [ADDR_W-1:0] Read_Address;
   logic [31:0]       IF_ID_Instruction;
   logic [ADDR_W-1:0] IF_ID_PC_Plus1;
   logic              IF_ID_Valid;
   logic              Halted;

   modport master (
      input  Stall,
      input  Branch_Taken,
      input  Branch_Offset,
      input  Jump,
      input  Jump_Target,
      input  Instruction,
      output Read_Address,
      output IF_ID_Instruction,
      output IF_ID_PC_Plus1,
      output IF_ID_Valid,
      output Halted
   );

   modport slave (
      output Stall,
      output Branch_Taken,
      output Branch_Offset,
      output Jump,
      output Jump_Target,
      output Instruction,
      input  Read_Address,
      input  IF_ID_Instruction,
      input  IF_ID_PC_Plus1,
      input  IF_ID_Valid,
      input  Halted
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the word-addressed PC, drives the
// instruction-memory read address, and captures the returned word into the
// IF/ID pipeline register. Supports stall, jump/branch redirect with a
// single-bubble flush, and a sticky halt on HALT_WORD.
// Ports:
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset
//   bus   : pc_fetch_unit_if.master (decode control, memory data, IF/ID outputs)
module pc_fetch_unit #(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       HALT_WORD = '1
) (
   input  logic             Clk,
   input  logic             Rst_n,
   pc_fetch_unit_if.master  bus
);

   typedef enum logic {
      S_FETCH  = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic [ADDR_W-1:0] ifid_pc1_q, ifid_pc1_d;
   logic              ifid_valid_q, ifid_valid_d;

   logic [ADDR_W-1:0] pc_plus1;
   logic [ADDR_W-1:0] branch_target;

   assign pc_plus1 = pc_q + ADDR_W'(1);
   // Offset and PC share the same width, so a plain modular add is identical
   // to sign-extending the offset and truncating the sum.
   assign branch_target = ifid_pc1_q + bus.Branch_Offset;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc1_d   = ifid_pc1_q;
      ifid_valid_d = ifid_valid_q;

      unique case (state_q)
         S_FETCH: begin
            if (bus.Jump) begin
               pc_d         = bus.Jump_Target;
               ifid_instr_d = '0;
               ifid_valid_d = 1'b0;
            end else if (bus.Branch_Taken) begin
               pc_d         = branch_target;
               ifid_instr_d = '0;
               ifid_valid_d = 1'b0;
            end else if (bus.Stall) begin
               // hold everything
            end else if (bus.Instruction == HALT_WORD) begin
               // halt word is passed down once, then fetch freezes on it
               ifid_instr_d = HALT_WORD;
               ifid_pc1_d   = pc_plus1;
               ifid_valid_d = 1'b1;
               state_d      = S_HALTED;
            end else begin
               ifid_instr_d = bus.Instruction;
               ifid_pc1_d   = pc_plus1;
               ifid_valid_d = 1'b1;
               pc_d         = pc_plus1;
            end
         end
         S_HALTED: begin
            ifid_valid_d = 1'b0;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc1_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc1_q   <= ifid_pc1_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign bus.Read_Address      = pc_q;
   assign bus.IF_ID_Instruction = ifid_instr_q;
   assign bus.IF_ID_PC_Plus1    = ifid_pc1_q;
   assign bus.IF_ID_Valid       = ifid_valid_q;
   assign bus.Halted            = (state_q == S_HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit. Instruction memory is modelled as a
// combinational array indexed by Read_Address; word i holds i unless
// overwritten. Observed state is packed as
// {Read_Address, IF_ID_Instruction, IF_ID_PC_Plus1, IF_ID_Valid, Halted}.
module tb_pc_fetch_unit;

   logic Clk;
   logic Rst_n;
   logic [31:0] mem [256];
   logic [49:0] exp;
   int checks;
   int errors;

   pc_fetch_unit_if #(.ADDR_W(8)) bus ();

   pc_fetch_unit #(
      .ADDR_W   (8),
      .RESET_PC (8'h00),
      .HALT_WORD(32'hFFFF_FFFF)
   ) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .bus  (bus)
   );

   assign bus.Instruction = mem[bus.Read_Address];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [49:0] snap();
      return {bus.Read_Address, bus.IF_ID_Instruction, bus.IF_ID_PC_Plus1,
              bus.IF_ID_Valid, bus.Halted};
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.Stall         = 1'b0;
      bus.Branch_Taken  = 1'b0;
      bus.Branch_Offset = 8'h00;
      bus.Jump          = 1'b0;
      bus.Jump_Target   = 8'h00;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      idle_inputs();
      #12;
      exp = {8'd0, 32'd0, 8'd0, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL reset_state: got %h, expected %h", snap(), exp);
      end
      Rst_n = 1'b1;
      #1;
      exp = {8'd0, 32'd0, 8'd0, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL reset_release: got %h, expected %h", snap(), exp);
      end
   endtask

   task automatic test_sequential();
      for (int unsigned i = 1; i <= 5; i++) begin
         step();
         exp = {8'(i), 32'(i - 1), 8'(i), 1'b1, 1'b0};
         checks++;
         if (snap() !== exp) begin
            errors++;
            $display("FAIL seq_edge%0d: got %h, expected %h", i, snap(), exp);
         end
      end
   endtask

   task automatic test_stall();
      bus.Stall = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         step();
         exp = {8'd5, 32'd4, 8'd5, 1'b1, 1'b0};
         checks++;
         if (snap() !== exp) begin
            errors++;
            $display("FAIL stall_hold%0d: got %h, expected %h", i, snap(), exp);
         end
      end
      bus.Stall = 1'b0;
      step();
      exp = {8'd6, 32'd5, 8'd6, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL stall_resume: got %h, expected %h", snap(), exp);
      end
   endtask

   task automatic test_branch();
      step();
      step();
      exp = {8'd8, 32'd7, 8'd8, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL branch_setup: got %h, expected %h", snap(), exp);
      end
      bus.Branch_Taken  = 1'b1;
      bus.Branch_Offset = 8'hFC;
      step();
      exp = {8'd4, 32'd0, 8'd8, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL branch_bubble: got %h, expected %h", snap(), exp);
      end
      idle_inputs();
      step();
      exp = {8'd5, 32'd4, 8'd5, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL branch_target_fetch: got %h, expected %h", snap(), exp);
      end
   endtask

   task automatic test_jump_priority();
      bus.Jump          = 1'b1;
      bus.Jump_Target   = 8'd200;
      bus.Branch_Taken  = 1'b1;
      bus.Branch_Offset = 8'd3;
      bus.Stall         = 1'b1;
      step();
      exp = {8'd200, 32'd0, 8'd5, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL jump_priority: got %h, expected %h", snap(), exp);
      end
      idle_inputs();
      step();
      exp = {8'd201, 32'd200, 8'd201, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL jump_target_fetch: got %h, expected %h", snap(), exp);
      end
   endtask

   task automatic test_wrap();
      bus.Jump        = 1'b1;
      bus.Jump_Target = 8'd254;
      step();
      idle_inputs();
      exp = {8'd254, 32'd0, 8'd201, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL wrap_jump: got %h, expected %h", snap(), exp);
      end
      step();
      exp = {8'd255, 32'd254, 8'd255, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL wrap_255: got %h, expected %h", snap(), exp);
      end
      step();
      exp = {8'd0, 32'd255, 8'd0, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL wrap_to_0: got %h, expected %h", snap(), exp);
      end
      step();
      exp = {8'd1, 32'd0, 8'd1, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL wrap_after: got %h, expected %h", snap(), exp);
      end
   endtask

   task automatic test_halt();
      mem[10] = 32'hFFFF_FFFF;
      bus.Jump        = 1'b1;
      bus.Jump_Target = 8'd9;
      step();
      idle_inputs();
      step();
      exp = {8'd10, 32'd9, 8'd10, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL halt_approach: got %h, expected %h", snap(), exp);
      end
      // branch back to 10 while the halt word sits at Read_Address
      bus.Branch_Taken  = 1'b1;
      bus.Branch_Offset = 8'd0;
      step();
      idle_inputs();
      exp = {8'd10, 32'd0, 8'd10, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL halt_squashed: got %h, expected %h", snap(), exp);
      end
      step();
      exp = {8'd10, 32'hFFFF_FFFF, 8'd11, 1'b1, 1'b1};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL halt_capture: got %h, expected %h", snap(), exp);
      end
      bus.Jump        = 1'b1;
      bus.Jump_Target = 8'd50;
      for (int unsigned i = 0; i < 2; i++) begin
         step();
         exp = {8'd10, 32'hFFFF_FFFF, 8'd11, 1'b0, 1'b1};
         checks++;
         if (snap() !== exp) begin
            errors++;
            $display("FAIL halt_sticky%0d: got %h, expected %h", i, snap(), exp);
         end
      end
      idle_inputs();
      #3;
      Rst_n = 1'b0;
      #1;
      exp = {8'd0, 32'd0, 8'd0, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL halt_async_reset: got %h, expected %h", snap(), exp);
      end
      #2;
      Rst_n = 1'b1;
      step();
      exp = {8'd1, 32'd0, 8'd1, 1'b1, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL halt_restart: got %h, expected %h", snap(), exp);
      end
   endtask

   task automatic test_branch_neg_wrap();
      // IF_ID_PC_Plus1 = 1, offset -2 -> target 255
      bus.Branch_Taken  = 1'b1;
      bus.Branch_Offset = 8'hFE;
      step();
      idle_inputs();
      exp = {8'd255, 32'd0, 8'd1, 1'b0, 1'b0};
      checks++;
      if (snap() !== exp) begin
         errors++;
         $display("FAIL branch_neg_wrap: got %h, expected %h", snap(), exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_jump_priority();
      test_wrap();
      test_halt();
      test_branch_neg_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the 8-bit word-addressed program counter and drives the memory's read address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with single-bubble flush, and a sticky halt on a designated halt word.

Parameters:
- ADDR_W, 8, PC / read-address width in words (256-entry instruction memory).
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Stall  input  1  hazard stall from decode; hold PC and IF/ID
- Branch_Taken  input  1  taken branch resolved in decode
- Branch_Offset  input  8  signed word offset, relative to IF_ID_PC_Plus1
- Jump  input  1  absolute jump from decode
- Jump_Target  input  8  absolute word address
- Instruction  input  32  combinational read data from instruction memory
- Read_Address  output  8  current PC, to instruction memory
- IF_ID_Instruction  output  32  registered fetched instruction
- IF_ID_PC_Plus1  output  8  registered PC+1 of that instruction
- IF_ID_Valid  output  1  IF/ID holds a real instruction
- Halted  output  1  fetch permanently stopped until reset

Behaviour:
- Reset:
  - Asynchronous on Rst_n=0; all registers update immediately, independent of Clk.
  - PC=RESET_PC, IF_ID_Instruction=0, IF_ID_PC_Plus1=0, IF_ID_Valid=0, Halted=0, state=FETCH.
  - First real fetch is captured on the first rising edge after Rst_n rises.
- Read path:
  - Read_Address = PC, a direct register output with no logic after the flop.
  - Instruction is sampled in the same cycle; memory is zero-latency.
- States:
  - FETCH: normal operation.
  - HALTED: absorbing; PC, IF_ID_Instruction and IF_ID_PC_Plus1 hold, IF_ID_Valid=0, Halted=1. All inputs are ignored; only reset exits.
- Per-edge priority in FETCH, first match wins:
  1. Jump: PC<=Jump_Target; IF_ID_Valid<=0; IF_ID_Instruction<=0.
  2. Branch_Taken: PC<=IF_ID_PC_Plus1 + Branch_Offset (sign-extended, mod 256); IF_ID_Valid<=0; IF_ID_Instruction<=0.
  3. Stall: PC and all IF/ID outputs hold.
  4. Instruction==HALT_WORD: PC holds; IF_ID_Instruction<=HALT_WORD; IF_ID_PC_Plus1<=PC+1; IF_ID_Valid<=1; state<=HALTED. Halted=1 from the next cycle; IF_ID_Valid=0 one cycle after capture.
  5. Otherwise: IF_ID_Instruction<=Instruction; IF_ID_PC_Plus1<=PC+1; IF_ID_Valid<=1; PC<=PC+1.
- Redirect latency: the target address appears on Read_Address the cycle after the redirect edge; exactly one bubble is inserted.
- Simultaneous events:
  - Jump+Branch_Taken: jump wins.
  - Redirect+Stall: redirect wins; the stalled fetch is squashed.
  - Redirect while the halt word is at Read_Address: redirect wins and no halt occurs, since the halt was speculative.
- Arithmetic and wrap:
  - All PC arithmetic is modulo 2^ADDR_W.
  - PC=255 increments to 0 with IF_ID_PC_Plus1=0.
  - A branch target below 0 or above 255 wraps.
- Reset mid-operation (including during stall or HALTED): immediate return to reset values; no pending redirect survives.

Test Plan:
1. Reset release, memory word i = i, no stalls -> Read_Address 0,1,2,3 on successive cycles; IF_ID_Instruction 0,1,2 with IF_ID_PC_Plus1 1,2,3 and IF_ID_Valid=1 from the first post-reset edge.
2. Stall held 3 cycles at PC=5 -> Read_Address stays 5; IF_ID holds instruction 4 / PC_Plus1 5; fetch resumes with instruction 5 on the first unstalled edge.
3. Branch_Taken with IF_ID_PC_Plus1=8, Branch_Offset=8'hFC -> next Read_Address=4; IF_ID_Valid=0 for one cycle; then instruction 4 valid.
4. Jump=1, Jump_Target=200 asserted together with Branch_Taken and Stall -> Read_Address=200 next cycle; branch and stall are ignored.
5. PC run from 254 -> Read_Address 254,255,0; IF_ID_PC_Plus1 for word 255 is 0.
6. Word 10 = HALT_WORD:
   - Halt word captured valid, then Halted=1, IF_ID_Valid=0, Read_Address stuck at 10 despite Jump pulses.
   - Rst_n low mid-cycle -> Read_Address=0 and Halted=0 immediately, without a clock edge.
